// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, req/ready handshake, acks and stalls.
// Optional BUSY watchdog with bus_err abort is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                bus_err
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t     r_state;
    logic       r_own_d;
    logic [3:0] r_burst;
    logic       w_d_any;
    logic       w_pick_d;

    assign w_d_any   = d_read | d_write;
    // Data wins unless a waiting fetch has already been passed over MAX_DATA_BURST times.
    assign w_pick_d  = w_d_any & ~(if_req & (r_burst == BURST_MAX));
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = w_d_any & ~d_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_bus_err;

    assign bus_err = r_bus_err;
`else
    logic w_unused_tmo;

    // The watchdog limit has no meaning without the timeout build.
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign bus_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_own_d   <= 1'b0;
            r_burst   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_wdog    <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_d_any || if_req) begin
                        r_state <= BUSY;
                        mem_req <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                        if (w_pick_d) begin
                            r_own_d   <= 1'b1;
                            mem_we    <= d_write;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                            r_burst   <= if_req ? r_burst + 4'd1 : 4'd0;
                        end else begin
                            r_own_d   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            r_burst   <= '0;
                        end
                    end else begin
                        r_burst <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= RESP;
                        if (r_own_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (r_wdog == WD_LAST) begin
                        mem_req   <= 1'b0;
                        r_state   <= RESP;
                        r_bus_err <= 1'b1;
                        if (r_own_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model checked every cycle plus directed cases.
// The timeout case is compiled in only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    localparam int TB_TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        stall_if, stall_mem;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        bus_err;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: W wait states per transaction, or never ready when hang is set.
    int W = 0;
    bit hang = 1'b0;
    int rcnt = 0;
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            mem_ready = !hang && (rcnt == W);
            mem_rdata = mem_ready ? rdfun(mem_addr) : 32'hBAD0_BAD0;
            rcnt++;
        end else begin
            rcnt = 0;
            mem_ready = 1'b0;
        end
    end

    // Grant order log: data addresses live at 0x2000 and above, fetch addresses below.
    byte gq[$];
    bit  prev_req = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset && mem_req && !prev_req) gq.push_back(mem_addr[13] ? "D" : "I");
        prev_req = mem_req;
    end

    // Schedule model: when the arbiter is idle it grants by priority/burst rule, then the
    // transaction occupies mem_req for W+1 cycles, acks one cycle later, idles one cycle.
    int          idle_at = 0;
    bit          have = 1'b0;
    bit          t_d, t_we, t_to, dreq, exp_req, eack;
    logic [31:0] t_addr, t_wdata, rdx;
    logic [3:0]  t_wstrb;
    int          t_start, t_end, t_ack;
    int          bursts = 0;
    logic [31:0] e_if_rd = '0;
    logic [31:0] e_d_rd = '0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("rst_ctrl", 64'({mem_req, mem_we, if_ack, d_ack, bus_err, mem_wstrb}), 64'd0);
            chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
            chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
            have = 1'b0; idle_at = cyc + 1; e_if_rd = '0; e_d_rd = '0; bursts = 0;
        end else begin
            if (cyc == idle_at) begin
                dreq = d_read || d_write;
                if (dreq || if_req) begin
                    t_d = dreq && !(if_req && bursts == 4);
                    if (t_d) bursts = if_req ? bursts + 1 : 0;
                    else bursts = 0;
                    t_addr  = t_d ? d_addr : if_addr;
                    t_we    = t_d && d_write;
                    t_wdata = d_wdata;
                    t_wstrb = d_wstrb;
                    t_to    = hang;
                    t_start = cyc + 1;
                    t_end   = hang ? cyc + TB_TMO : cyc + 1 + W;
                    t_ack   = t_end + 1;
                    idle_at = t_ack + 1;
                    have    = 1'b1;
                end else begin
                    bursts  = 0;
                    idle_at = cyc + 1;
                end
            end
            exp_req = have && cyc >= t_start && cyc <= t_end;
            eack    = have && cyc == t_ack;
            if (eack) begin
                rdx = t_to ? 32'h0 : rdfun(t_addr);
                if (t_d) begin
                    if (!t_we || t_to) e_d_rd = rdx;
                end else begin
                    e_if_rd = rdx;
                end
            end
            chk("mem_req", 64'(mem_req), 64'(exp_req));
            if (exp_req) begin
                chk("mem_addr", 64'(mem_addr), 64'(t_addr));
                chk("mem_we", 64'(mem_we), 64'(t_we));
                if (t_we) begin
                    chk("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
                    chk("mem_wstrb", 64'(mem_wstrb), 64'(t_wstrb));
                end
            end
            chk("if_ack", 64'(if_ack), 64'(eack && !t_d));
            chk("d_ack", 64'(d_ack), 64'(eack && t_d));
            chk("if_rdata", 64'(if_rdata), 64'(e_if_rd));
            chk("d_rdata", 64'(d_rdata), 64'(e_d_rd));
            chk("bus_err", 64'(bus_err), 64'(eack && t_to));
            chk("stall_if", 64'(stall_if), 64'(if_req && !(eack && !t_d)));
            chk("stall_mem", 64'(stall_mem), 64'((d_read || d_write) && !(eack && t_d)));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch_once(input logic [31:0] a, output int lat, output logic [31:0] rdv,
                              output int nreq, output int nst);
        int t0;
        if_addr = a; if_req = 1'b1; t0 = cyc; lat = -1; rdv = '0; nreq = 0; nst = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stall_if) nst++;
            if (mem_req) begin
                nreq++;
                chk("fetch_mem_addr", 64'(mem_addr), 64'(a));
            end
            if (if_ack) begin
                lat = cyc - t0; rdv = if_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic data_once(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws,
                             output int lat, output logic [31:0] rdv, output int nreq,
                             output bit berr);
        int t0;
        d_addr = a; d_wdata = wd; d_wstrb = ws; d_read = rd; d_write = wr;
        t0 = cyc; lat = -1; rdv = '0; nreq = 0; berr = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                chk("data_mem_we", 64'(mem_we), 64'(wr));
                if (wr) begin
                    chk("data_mem_wdata", 64'(mem_wdata), 64'(wd));
                    chk("data_mem_wstrb", 64'(mem_wstrb), 64'(ws));
                end
            end
            if (d_ack) begin
                lat = cyc - t0; rdv = d_rdata; berr = bus_err;
                break;
            end
        end
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic wait_ack(input bit is_fetch, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (is_fetch ? if_ack : d_ack) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int          lat, nreq, nst, dack_c, ireq_c, t0;
    logic [31:0] rdv;
    bit          berr, ok_i, ok_d;
    string       exp_order;

    initial begin
        step(3);
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_acks", 64'({if_ack, d_ack, bus_err}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(3);
        chk("idle_mem_req", 64'(mem_req), 64'd0);

        // Fetch only, zero-wait memory.
        W = 0;
        fetch_once(32'h100, lat, rdv, nreq, nst);
        chk("t1_ack_latency", 64'(lat), 64'd2);
        chk("t1_if_rdata", 64'(rdv), 64'h13);
        chk("t1_req_cycles", 64'(nreq), 64'd1);
        chk("t1_stall_cycles", 64'(nst), 64'd2);
        step(2);

        // Load and fetch together, two wait states: data first.
        W = 2;
        d_addr = 32'h2040; d_read = 1'b1; d_write = 1'b0;
        if_addr = 32'h104; if_req = 1'b1;
        t0 = cyc; dack_c = -1; ireq_c = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h104 && ireq_c < 0) ireq_c = cyc - t0;
            if (d_ack && dack_c < 0) begin
                dack_c = cyc - t0;
                @(posedge clk); #1;
                d_read = 1'b0;
            end else if (if_ack) begin
                @(posedge clk); #1;
                if_req = 1'b0;
                break;
            end
        end
        chk("t2_dack_cycle", 64'(dack_c), 64'd4);
        chk("t2_fetch_req_cycle", 64'(ireq_c), 64'd6);
        step(2);

        // Continuous loads plus a held fetch: burst limit forces fetch every fifth grant.
        W = 0;
        gq.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    if_addr = 32'h180 + 32'(4 * i); if_req = 1'b1;
                    wait_ack(1'b1, ok_i);
                    chk("t3_fetch_ack_seen", 64'(ok_i), 64'd1);
                end
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    d_addr = 32'h2100 + 32'(4 * i); d_read = 1'b1;
                    wait_ack(1'b0, ok_d);
                    chk("t3_load_ack_seen", 64'(ok_d), 64'd1);
                end
                d_read = 1'b0;
            end
        join
        step(2);
        exp_order = "DDDDIDDDDI";
        chk("t3_grant_count", 64'(gq.size()), 64'd10);
        for (int i = 0; i < 10 && i < gq.size(); i++)
            chk($sformatf("t3_grant_%0d", i), 64'(gq[i]), 64'(exp_order.getc(i)));
        chk("t3_last_load_rdata", 64'(d_rdata), 64'h211C_DEE3);

        // Store with partial strobes; load data register must not move.
        W = 1;
        data_once(1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, lat, rdv, nreq, berr);
        chk("t4_ack_latency", 64'(lat), 64'd3);
        chk("t4_req_cycles", 64'(nreq), 64'd2);
        chk("t4_d_rdata_kept", 64'(rdv), 64'h211C_DEE3);
        step(1);

        // Read and write together behaves as a store.
        W = 0;
        data_once(1'b1, 1'b1, 32'h2008, 32'h1234_5678, 4'hF, lat, rdv, nreq, berr);
        chk("t4b_d_rdata_kept", 64'(rdv), 64'h211C_DEE3);
        data_once(1'b1, 1'b0, 32'h2010, 32'h0, 4'h0, lat, rdv, nreq, berr);
        chk("t4c_load_latency", 64'(lat), 64'd2);
        chk("t4c_load_rdata", 64'(rdv), 64'h2010_DFEF);
        step(1);

        // Reset in the middle of a slow fetch.
        W = 3;
        if_addr = 32'h140; if_req = 1'b1;
        ok_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ok_i = 1'b1;
                break;
            end
        end
        chk("t5_busy_reached", 64'(ok_i), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t5_async_ctrl", 64'({mem_req, mem_we, if_ack, d_ack, bus_err}), 64'd0);
        chk("t5_async_addr", 64'(mem_addr), 64'd0);
        chk("t5_async_rdata", {if_rdata, d_rdata}, 64'd0);
        if_req = 1'b0;
        step(2);
        reset = 1'b1;
        W = 0;
        fetch_once(32'h100, lat, rdv, nreq, nst);
        chk("t5_after_latency", 64'(lat), 64'd2);
        chk("t5_after_rdata", 64'(rdv), 64'h13);
        step(2);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog aborts the load.
        hang = 1'b1;
        data_once(1'b1, 1'b0, 32'h2200, 32'h0, 4'h0, lat, rdv, nreq, berr);
        hang = 1'b0;
        chk("t6_abort_latency", 64'(lat), 64'd9);
        chk("t6_busy_cycles", 64'(nreq), 64'd8);
        chk("t6_bus_err", 64'(berr), 64'd1);
        chk("t6_d_rdata_zero", 64'(rdv), 64'd0);
        step(1);
        chk("t6_back_idle", 64'(mem_req), 64'd0);
        fetch_once(32'h100, lat, rdv, nreq, nst);
        chk("t6_after_rdata", 64'(rdv), 64'h13);
        step(2);
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester.
- The load/store requester is driven by the decoder's MemRead/MemWrite.
- The block sequences each memory transaction with a req/ready handshake, returns read data and acks, and generates pipeline stall signals.
- It sits between the fetch/MEM stages and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending; range 1..15
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- d_read  in  1  load request (MemRead), held until d_ack
- d_write  in  1  store request (MemWrite), held until d_ack
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle load/store completion pulse
- stall_if  out  1  fetch stall
- stall_mem  out  1  MEM-stage stall
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- bus_err  out  1  timeout abort pulse; tied to 0 without the optional feature

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (reset=0, async):
  - FSM goes to IDLE; burst counter and watchdog clear.
  - All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata, if_ack, d_ack, bus_err.
  - An in-flight memory transaction is dropped; no ack is issued for it.
- IDLE:
  - If any request is present, select an owner, latch the owner's addr/wdata/wstrb/we into the mem_* registers, and go to BUSY.
  - mem_req=1 from the next cycle.
- Arbitration (evaluated only in IDLE):
  - Data has priority over fetch.
  - If if_req=1 and the burst counter equals MAX_DATA_BURST, fetch wins.
  - Burst counter increments on each data grant while if_req=1.
  - Burst counter clears on a fetch grant, or in any IDLE cycle with if_req=0.
- BUSY:
  - mem_req=1; mem_* held stable.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register, drop mem_req, go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle, then go to IDLE.
  - Stores do not update d_rdata.
- Requesters must update or drop requests at the edge ending the ack cycle. Requests are never sampled in BUSY or RESP.
- Latency: with a zero-wait memory (mem_ready=1 on the first mem_req cycle), the ack comes 2 cycles after the request is sampled in IDLE. Back-to-back throughput is one transaction per 3 cycles.
- d_read=1 and d_write=1 together: treated as a store (mem_we=1).
- Stalls are combinational:
  - stall_if = if_req & ~if_ack
  - stall_mem = (d_read | d_write) & ~d_ack
- Request dropped before its ack (pipeline flush): the transaction still completes and is acked, and the ack is ignored by the pipeline. Requests are not cancellable.
- Holding reset high with no requests keeps the block in IDLE; all outputs stay 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts BUSY cycles.
  - When the count reaches TIMEOUT_CYCLES with no mem_ready: drop mem_req, go to RESP, force the owner's rdata to 0, and assert bus_err together with the owner's ack for one cycle.
  - Watchdog clears on entering BUSY.
- Undefined: no watchdog; BUSY waits indefinitely; bus_err is tied to 0.

Test Plan:
- Fetch only, zero-wait memory, if_addr=0x100, mem_rdata=0x00000013 -> mem_req high for 1 cycle with mem_addr=0x100; if_ack at cycle 2 with if_rdata=0x00000013; stall_if high in cycles 0..1.
- Fetch and load held simultaneously, memory with 2 wait states -> data granted first; d_ack at cycle 4; fetch mem_req starts at cycle 6.
- Continuous loads plus a held fetch, MAX_DATA_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Store with d_wstrb=4'b0011, d_wdata=0xDEADBEEF, addr=0x2000 -> mem_we=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF held until mem_ready; d_ack pulses; d_rdata unchanged.
- reset driven low during BUSY -> all outputs 0 immediately; no ack; after release, the next request is handled normally from IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0 -> after 8 BUSY cycles bus_err=1 and d_ack=1 in the same cycle, d_rdata=0, FSM returns to IDLE.
